// File: rtl/day1_pkg.sv
// Shared types and ASCII constants for the day-1 puzzle text reader.
package day1_pkg;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } rotDir_t;

  typedef enum logic [2:0] {
    S_DIR,
    S_NUM,
    S_SKIP,
    S_EMIT,
    S_DONE
  } parse_state_t;

  localparam logic [7:0] CH_L  = 8'h4C;
  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_NL = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_9  = 8'h39;

endpackage

// File: rtl/day1_parser_if.sv
// Byte-stream input and record output handshakes of the day-1 parser.
interface day1_parser_if #(
  parameter int unsigned CLICK_WIDTH = 32
);
  import day1_pkg::*;

  logic [7:0]             in_data;
  logic                   in_valid;
  logic                   in_last;
  logic                   in_ready;
  rotDir_t                direction;
  logic [CLICK_WIDTH-1:0] clicks;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, direction, clicks, out_valid
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, direction, clicks, out_valid
  );

endinterface

// File: rtl/dec_accum.sv
// Decimal accumulator: clear, step acc*10+digit, clamp to all-ones on overflow.
module dec_accum #(
  parameter int unsigned CLICK_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   clear_i,
  input  logic                   step_i,
  input  logic [3:0]             digit_i,
  output logic [CLICK_WIDTH-1:0] acc_o
);

  logic [CLICK_WIDTH-1:0] acc_q, acc_d;
  logic [CLICK_WIDTH+3:0] prod;

  // Four extra bits hold (2^W-1)*10+9, so any overflow shows up in the top nibble.
  always_comb begin
    prod  = {4'b0000, acc_q} * (CLICK_WIDTH+4)'(10) + (CLICK_WIDTH+4)'(digit_i);
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (step_i) begin
      acc_d = (|prod[CLICK_WIDTH+3:CLICK_WIDTH]) ? '1 : prod[CLICK_WIDTH-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) acc_q <= '0;
    else          acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/day1_parser.sv
// Turns "L68\n"-style ASCII lines into (direction, clicks) records, counting malformed lines.
module day1_parser
  import day1_pkg::*;
#(
  parameter int unsigned CLICK_WIDTH = 32,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  day1_parser_if.slave           bus,
  output logic [COUNT_WIDTH-1:0] rec_count,
  output logic [COUNT_WIDTH-1:0] err_count,
  output logic                   done
);

  parse_state_t           state_q, state_d;
  rotDir_t                dir_q, dir_d;
  logic                   seen_q, seen_d;
  logic                   last_q, last_d;
  logic                   in_ready_q, out_valid_q, done_q;
  logic [COUNT_WIDTH-1:0] rec_q, err_q;
  logic                   acc_clr, acc_step, err_inc, rec_inc;
  logic                   accept, is_digit, is_nl, is_cr, is_dir;
  logic [CLICK_WIDTH-1:0] acc;

  dec_accum #(.CLICK_WIDTH(CLICK_WIDTH)) u_acc (
    .clock   (clock),
    .reset_n (reset_n),
    .clear_i (acc_clr),
    .step_i  (acc_step),
    .digit_i (bus.in_data[3:0]),
    .acc_o   (acc)
  );

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    seen_d   = seen_q;
    last_d   = last_q;
    acc_clr  = 1'b0;
    acc_step = 1'b0;
    err_inc  = 1'b0;
    rec_inc  = 1'b0;
    accept   = in_ready_q && bus.in_valid;
    is_digit = (bus.in_data >= CH_0) && (bus.in_data <= CH_9);
    is_nl    = (bus.in_data == CH_NL);
    is_cr    = (bus.in_data == CH_CR);
    is_dir   = (bus.in_data == CH_L) || (bus.in_data == CH_R);
    unique case (state_q)
      S_DIR: if (accept) begin
        if (is_dir) begin
          dir_d   = (bus.in_data == CH_L) ? LEFT : RIGHT;
          acc_clr = 1'b1;
          seen_d  = 1'b0;
          state_d = S_NUM;
          if (bus.in_last) begin
            err_inc = 1'b1;
            state_d = S_DONE;
          end
        end else if (is_nl || is_cr) begin
          if (bus.in_last) state_d = S_DONE;
        end else begin
          err_inc = 1'b1;
          state_d = bus.in_last ? S_DONE : S_SKIP;
        end
      end
      // A stream ending mid-number still yields the record once digits exist.
      S_NUM: if (accept) begin
        if (is_digit) begin
          acc_step = 1'b1;
          seen_d   = 1'b1;
          if (bus.in_last) begin
            last_d  = 1'b1;
            state_d = S_EMIT;
          end
        end else if (is_cr) begin
          if (bus.in_last) begin
            if (seen_q) begin
              last_d  = 1'b1;
              state_d = S_EMIT;
            end else begin
              err_inc = 1'b1;
              state_d = S_DONE;
            end
          end
        end else if (is_nl) begin
          if (seen_q) begin
            last_d  = bus.in_last;
            state_d = S_EMIT;
          end else begin
            err_inc = 1'b1;
            state_d = bus.in_last ? S_DONE : S_DIR;
          end
        end else begin
          err_inc = 1'b1;
          state_d = bus.in_last ? S_DONE : S_SKIP;
        end
      end
      S_SKIP: if (accept) begin
        if (is_nl) begin
          state_d = bus.in_last ? S_DONE : S_DIR;
        end else if (bus.in_last) begin
          err_inc = 1'b1;
          state_d = S_DONE;
        end
      end
      S_EMIT: if (bus.out_ready) begin
        rec_inc = 1'b1;
        last_d  = 1'b0;
        state_d = last_q ? S_DONE : S_DIR;
      end
      S_DONE: ;
      default: state_d = S_DIR;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_DIR;
      dir_q       <= LEFT;
      seen_q      <= 1'b0;
      last_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      rec_q       <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      seen_q      <= seen_d;
      last_q      <= last_d;
      in_ready_q  <= (state_d == S_DIR) || (state_d == S_NUM) || (state_d == S_SKIP);
      out_valid_q <= (state_d == S_EMIT);
      done_q      <= (state_d == S_DONE);
      if (rec_inc && (rec_q != '1)) rec_q <= rec_q + 1'b1;
      if (err_inc && (err_q != '1)) err_q <= err_q + 1'b1;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.direction = dir_q;
  assign bus.clicks    = acc;
  assign rec_count     = rec_q;
  assign err_count     = err_q;
  assign done          = done_q;

endmodule

// File: tb/tb_day1_parser.sv
// Scoreboard bench for day1_parser: directed ASCII streams with hand-computed records.
module tb_day1_parser;
  import day1_pkg::*;

  typedef struct {
    rotDir_t     dir;
    logic [31:0] clicks;
  } rec_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] rec_count, err_count;
  logic        done;
  int          n_cmp = 0;
  int          n_err = 0;
  rec_t        exp_q[$];

  day1_parser_if #(.CLICK_WIDTH(32)) bus ();

  day1_parser #(.CLICK_WIDTH(32), .COUNT_WIDTH(16)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus),
    .rec_count (rec_count),
    .err_count (err_count),
    .done      (done)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted record is checked against the scoreboard head.
  initial begin
    rec_t e;
    forever begin
      @(negedge clock);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_record", 64'(bus.clicks), 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          check("rec_dir", 64'(bus.direction), 64'(e.dir));
          check("rec_clicks", 64'(bus.clicks), 64'(e.clicks));
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, input bit last);
    int n = 0;
    @(negedge clock);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    while (!bus.in_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!bus.in_ready) check("send_timeout", 64'(n), 64'd0);
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Sends a line; after each accepted '\n' out_valid must already be high.
  task automatic send_str(input string s, input bit last_on_final);
    for (int i = 0; i < s.len(); i++) begin
      send(s[i], last_on_final && (i == s.len() - 1));
      if (s[i] == CH_NL) check("ov_latency", 64'(bus.out_valid), 64'd1);
    end
  endtask

  task automatic push(input rotDir_t d, input logic [31:0] c);
    rec_t r;
    r.dir = d;
    r.clicks = c;
    exp_q.push_back(r);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_data = 8'h00;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_in_ready_low", 64'(bus.in_ready), 64'd1);
    reset_n = 1'b1;
    @(negedge clock);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_dir", 64'(bus.direction), 64'(LEFT));
    check("rst_clicks", 64'(bus.clicks), 64'd0);
    check("rst_rec", 64'(rec_count), 64'd0);
    check("rst_err", 64'(err_count), 64'd0);
    check("rst_done", 64'(done), 64'd0);

    push(LEFT, 32'd68);
    push(RIGHT, 32'd30);
    send_str("L68\nR30\n", 1'b0);
    drain();
    check("t1_rec", 64'(rec_count), 64'd2);
    check("t1_err", 64'(err_count), 64'd0);

    bus.out_ready = 1'b0;
    push(RIGHT, 32'd5);
    send_str("R5\n", 1'b0);
    bus.in_data = CH_L;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("stall_valid", 64'(bus.out_valid), 64'd1);
      check("stall_dir", 64'(bus.direction), 64'(RIGHT));
      check("stall_clicks", 64'(bus.clicks), 64'd5);
      check("stall_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid = 1'b0;
    @(posedge clock);
    #1;
    bus.out_ready = 1'b1;
    drain();
    check("stall_in_ready_after", 64'(bus.in_ready), 64'd1);
    check("t2_rec", 64'(rec_count), 64'd3);

    push(LEFT, 32'd7);
    send("X", 1'b0); send("1", 1'b0); send("2", 1'b0); send(CH_NL, 1'b0);
    send("L", 1'b0); send(CH_NL, 1'b0);
    send_str("L7\r\n", 1'b0);
    drain();
    check("t3_err", 64'(err_count), 64'd2);
    check("t3_rec", 64'(rec_count), 64'd4);

    push(RIGHT, 32'hFFFF_FFFF);
    send_str("R99999999999\n", 1'b0);
    drain();
    check("t4_rec", 64'(rec_count), 64'd5);

    send_str("L4", 1'b0);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_clicks", 64'(bus.clicks), 64'd0);
    check("mid_rst_dir", 64'(bus.direction), 64'(LEFT));
    check("mid_rst_rec", 64'(rec_count), 64'd0);
    check("mid_rst_err", 64'(err_count), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    push(RIGHT, 32'd1);
    send_str("R1\n", 1'b0);
    drain();
    check("t5_rec", 64'(rec_count), 64'd1);

    push(LEFT, 32'd3);
    send_str("L3", 1'b1);
    drain();
    check("last_done", 64'(done), 64'd1);
    check("last_rec", 64'(rec_count), 64'd2);
    check("last_err", 64'(err_count), 64'd0);
    bus.in_data = CH_R;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("done_in_ready", 64'(bus.in_ready), 64'd0);
      check("done_out_valid", 64'(bus.out_valid), 64'd0);
    end
    bus.in_valid = 1'b0;
    check("leftover_expected", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/day1_parser.md
Name: day1_parser

Overview:
- Hardware reader for the day-1 puzzle text format. It takes a raw ASCII byte stream of lines such as "L68\n" and "R5\n" and produces one (direction, clicks) record per line for the day1 dial core.
- It sits between a byte source (UART RX or ROM streamer) and day1. It replaces file parsing in the bench with synthesizable logic.
- Uses valid/ready handshakes on both sides and tracks malformed lines.

Parameters:
- CLICK_WIDTH, 32, width of the clicks output and accumulator.
- COUNT_WIDTH, 16, width of the record and error counters.

Ports:
- clock, input, 1, system clock; all state updates on its rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- in_data, input, 8, ASCII byte.
- in_valid, input, 1, in_data is valid.
- in_last, input, 1, qualifies the final byte of the stream (with in_valid).
- in_ready, output, 1, parser accepts the byte this cycle.
- direction, output, rotDir_t, LEFT/RIGHT of the current record.
- clicks, output, CLICK_WIDTH, decimal value of the current record.
- out_valid, output, 1, record presented.
- out_ready, input, 1, downstream accepts the record.
- rec_count, output, COUNT_WIDTH, records emitted so far.
- err_count, output, COUNT_WIDTH, malformed lines dropped.
- done, output, 1, sticky; the stream has ended and the final record has been accepted.

Behaviour:
- Reset (async, reset_n=0) puts the FSM in S_DIR and forces the following values: direction=LEFT, clicks=0, out_valid=0, rec_count=0, err_count=0, done=0, accumulator=0. in_ready is 1 in the first cycle after reset deasserts.
- Byte acceptance: a byte is accepted when in_valid && in_ready.
- in_ready is 1 only in S_DIR, S_NUM and S_SKIP. It is 0 in S_EMIT and once done is set.
- State S_DIR (expecting a line start):
  - 'L' latches LEFT, clears the accumulator and goes to S_NUM; 'R' does the same with RIGHT.
  - '\n' and '\r' are ignored (blank lines).
  - Any other byte increments err_count and goes to S_SKIP.
- State S_NUM:
  - Digit '0'..'9' updates acc = acc*10 + digit. If the true result exceeds 2^CLICK_WIDTH-1, acc saturates at all-ones and the line is still emitted.
  - '\r' is ignored.
  - '\n' with at least one digit seen goes to S_EMIT.
  - '\n' with zero digits increments err_count and goes to S_DIR.
  - Any other byte increments err_count and goes to S_SKIP.
- State S_SKIP: discard bytes until '\n', then go to S_DIR.
- State S_EMIT:
  - out_valid=1; clicks and direction are registered and stable until the handshake.
  - On out_valid && out_ready: rec_count increments, then go to S_DIR, or to S_DONE if the last flag is pending.
  - Latency: out_valid rises on the cycle after '\n' is accepted.
- in_last handling:
  - If accepted in S_NUM with digits seen (on a digit or '\r'), the line is treated as newline-terminated: a last flag is set and the FSM enters S_EMIT.
  - If accepted on '\n' that completes a record, the FSM enters S_EMIT with the last flag set.
  - Otherwise the FSM goes directly to S_DONE. An unterminated partial line (direction with no digits, or in S_SKIP) increments err_count.
- S_DONE: done=1, in_ready=0, out_valid=0. The FSM stays here until reset.
- Counters saturate at all-ones and do not wrap.
- Mid-operation reset: a partial line, a pending record and the counters are all discarded. Downstream must treat out_valid dropping as a reset.

Decomposition:
- day1_pkg holds:
  - rotDir_t (LEFT, RIGHT);
  - parser state enum (S_DIR, S_NUM, S_SKIP, S_EMIT, S_DONE);
  - ASCII constants CH_L, CH_R, CH_NL, CH_CR, CH_0, CH_9.
- Sub-module dec_accum holds the clear/step/saturate accumulator (acc*10+d computed in CLICK_WIDTH+4 bits, then clamped). It is instantiated once.

Test Plan:
- Stream "L68\nR30\n", out_ready=1 -> records (LEFT,68) then (RIGHT,30). out_valid rises 1 cycle after each '\n'. rec_count=2, err_count=0.
- "R5\n" with out_ready held 0 for 10 cycles -> out_valid, direction and clicks stay stable. in_ready=0 throughout; the next byte is accepted only after the handshake.
- "X12\nL\nL7\r\n" -> one record (LEFT,7). err_count=2.
- "R99999999999\n" -> clicks=32'hFFFFFFFF, rec_count=1.
- "L3" with in_last on '3' (no newline) -> record (LEFT,3). done=1 after accept; in_ready stays 0 afterwards.
- Assert reset_n=0 while the FSM is in S_NUM after "L4" -> all outputs return to reset values. A subsequent "R1\n" yields (RIGHT,1), rec_count=1.
